// File: rtl/epoch_barrier.sv
// Epoch barrier: per-port arrival/departure counters, a global epoch equal to
// the minimum arrival count over enabled ports, and per-port departure grants.
// All counter arithmetic is modulo 2^COUNT_WIDTH and compared wrap-safely.
module epoch_barrier #(
    parameter int PORT_COUNT  = 2,
    parameter int COUNT_WIDTH = 16,
    parameter int MAX_SKEW    = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PORT_COUNT-1:0]  s_inc,
    input  logic [PORT_COUNT-1:0]  s_dec,
    input  logic [PORT_COUNT-1:0]  port_en,
    output logic [PORT_COUNT:0]    ctrl_barrier,
    output logic [PORT_COUNT-1:0]  skew_stall,
    output logic [PORT_COUNT-1:0]  err_underflow,
    output logic [COUNT_WIDTH-1:0] epoch
);

    typedef logic [COUNT_WIDTH-1:0] cnt_t;

    localparam cnt_t HALF     = cnt_t'(1) << (COUNT_WIDTH - 1);
    localparam cnt_t SKEW_LIM = cnt_t'(MAX_SKEW);

    logic [PORT_COUNT-1:0][COUNT_WIDTH-1:0] in_cnt, out_cnt;
    logic [PORT_COUNT-1:0][COUNT_WIDTH-1:0] in_nxt, out_nxt;
    logic [PORT_COUNT-1:0]                  en_q;
    logic [PORT_COUNT-1:0]                  active, reload, uf_set;
    logic [PORT_COUNT-1:0]                  grant_nxt, stall_nxt;
    logic                                   aligned_nxt;
    cnt_t                                   epoch_nxt;

    // A port joins the minimum only once it has been enabled for a full cycle;
    // on the enabling cycle its counters are reloaded from the epoch instead.
    assign active = port_en & en_q;
    assign reload = port_en & ~en_q;

    // Next counter values: reload on re-enable, freeze while disabled,
    // drop stalled arrivals and ungranted departures.
    always_comb begin
        in_nxt  = in_cnt;
        out_nxt = out_cnt;
        uf_set  = '0;
        for (int i = 0; i < PORT_COUNT; i++) begin
            uf_set[i] = s_dec[i] & ~ctrl_barrier[i];
            if (reload[i]) begin
                in_nxt[i]  = epoch;
                out_nxt[i] = epoch;
            end else if (port_en[i]) begin
                if (s_inc[i] && !skew_stall[i])
                    in_nxt[i] = in_cnt[i] + cnt_t'(1);
                if (s_dec[i] && ctrl_barrier[i])
                    out_nxt[i] = out_cnt[i] + cnt_t'(1);
            end
        end
    end

    // Epoch advances by the smallest offset of any active port; offsets are
    // taken relative to the epoch so the compare survives counter wrap.
    always_comb begin
        cnt_t min_off;
        logic any_act;
        min_off = '1;
        any_act = 1'b0;
        for (int i = 0; i < PORT_COUNT; i++) begin
            if (active[i]) begin
                any_act = 1'b1;
                if (cnt_t'(in_cnt[i] - epoch) < min_off)
                    min_off = cnt_t'(in_cnt[i] - epoch);
            end
        end
        epoch_nxt = any_act ? cnt_t'(epoch + min_off) : epoch;
    end

    // Grants, alignment and stalls are computed from next-state values so a
    // departure retires its grant on the very next cycle.
    always_comb begin
        grant_nxt   = '0;
        stall_nxt   = '0;
        aligned_nxt = 1'b1;
        for (int i = 0; i < PORT_COUNT; i++) begin
            cnt_t lag_n;
            lag_n        = cnt_t'(epoch_nxt - out_nxt[i]);
            grant_nxt[i] = port_en[i] && (lag_n != '0) && (lag_n < HALF);
            stall_nxt[i] = cnt_t'(in_nxt[i] - out_nxt[i]) >= SKEW_LIM;
            if (port_en[i] && ((in_nxt[i] != epoch_nxt) || (lag_n != '0)))
                aligned_nxt = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_cnt        <= '0;
            out_cnt       <= '0;
            epoch         <= '0;
            ctrl_barrier  <= '0;
            skew_stall    <= '0;
            err_underflow <= '0;
            en_q          <= '1;
        end else begin
            in_cnt        <= in_nxt;
            out_cnt       <= out_nxt;
            epoch         <= epoch_nxt;
            ctrl_barrier  <= {aligned_nxt, grant_nxt};
            skew_stall    <= stall_nxt;
            err_underflow <= err_underflow | uf_set;
            en_q          <= port_en;
        end
    end

endmodule

// File: tb/tb_epoch_barrier.sv
// Scoreboard bench for epoch_barrier: expectations are queued as stimulus is
// driven and popped against the DUT once the outputs have settled.
module tb_epoch_barrier;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  s_inc, s_dec, port_en;
    logic [2:0]  ctrl_barrier;
    logic [1:0]  skew_stall, err_underflow;
    logic [15:0] epoch;

    // second instance with a tiny skew limit
    logic [1:0]  s_inc2, s_dec2, port_en2;
    logic [2:0]  ctrl_barrier2;
    logic [1:0]  skew_stall2, err_underflow2;
    logic [15:0] epoch2;

    always #5 clk = ~clk;

    epoch_barrier #(.PORT_COUNT(2), .COUNT_WIDTH(16), .MAX_SKEW(1024)) dut (
        .clk(clk), .rst(rst), .s_inc(s_inc), .s_dec(s_dec), .port_en(port_en),
        .ctrl_barrier(ctrl_barrier), .skew_stall(skew_stall),
        .err_underflow(err_underflow), .epoch(epoch)
    );

    epoch_barrier #(.PORT_COUNT(2), .COUNT_WIDTH(16), .MAX_SKEW(4)) dut2 (
        .clk(clk), .rst(rst), .s_inc(s_inc2), .s_dec(s_dec2), .port_en(port_en2),
        .ctrl_barrier(ctrl_barrier2), .skew_stall(skew_stall2),
        .err_underflow(err_underflow2), .epoch(epoch2)
    );

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  n_chk  = 0;
    int  n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            0:       return 32'(epoch);
            1:       return 32'(ctrl_barrier);
            2:       return 32'(skew_stall);
            3:       return 32'(err_underflow);
            4:       return 32'(dut.in_cnt[0]);
            5:       return 32'(dut.in_cnt[1]);
            6:       return 32'(dut.out_cnt[0]);
            7:       return 32'(dut.out_cnt[1]);
            8:       return 32'(skew_stall2);
            9:       return 32'(dut2.in_cnt[0]);
            default: return 32'hdead_beef;
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [31:0] exp);
        sb_t e;
        e.tag = tag; e.sel = sel; e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic sb_check();
        while (sb_q.size() > 0) begin
            sb_t e;
            e = sb_q.pop_front();
            chk(e.tag, observe(e.sel), e.exp);
        end
    endtask

    // one clock of stimulus, applied at the falling edge
    task automatic cyc(input logic [1:0] i, input logic [1:0] d);
        @(negedge clk);
        s_inc = i;
        s_dec = d;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(2'b00, 2'b00);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; s_inc = '0; s_dec = '0; s_inc2 = '0; s_dec2 = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; s_inc = '0; s_dec = '0; port_en = 2'b11;
        s_inc2 = '0; s_dec2 = '0; port_en2 = 2'b01;
        repeat (2) @(negedge clk);
        push("rst_epoch", 0, 0); push("rst_ctrl", 1, 0);
        push("rst_stall", 2, 0); push("rst_err", 3, 0);
        sb_check();
        rst = 1'b0;
        @(negedge clk);
        push("post_rst_aligned", 1, 3'b100);
        sb_check();

        // arrivals 3 on port0, 1 on port1
        cyc(2'b01, 2'b00); cyc(2'b01, 2'b00); cyc(2'b01, 2'b00); cyc(2'b10, 2'b00);
        idle(3);
        push("basic_epoch", 0, 1); push("basic_ctrl", 1, 3'b011);
        sb_check();
        cyc(2'b00, 2'b11); idle(2);
        push("basic_dec_ctrl", 1, 3'b000); push("basic_dec_err", 3, 0);
        sb_check();

        // grant latency: arrival completes epoch 2, grants two cycles later
        cyc(2'b10, 2'b00); cyc(2'b00, 2'b00); cyc(2'b00, 2'b00);
        push("latency_epoch", 0, 2); push("latency_ctrl", 1, 3'b011);
        sb_check();

        // simultaneous inc+dec on port0 at lag 1
        cyc(2'b01, 2'b01); cyc(2'b00, 2'b00);
        push("incdec_in0", 4, 4); push("incdec_out0", 6, 2);
        push("incdec_err", 3, 0); push("incdec_ctrl", 1, 3'b010);
        sb_check();

        // legal dec on port1, then an ungranted one
        cyc(2'b00, 2'b10); cyc(2'b00, 2'b10); cyc(2'b00, 2'b00);
        push("uf_err", 3, 2'b10); push("uf_out1", 7, 2); push("uf_ctrl", 1, 3'b000);
        sb_check();
        idle(3);
        push("uf_sticky", 3, 2'b10);
        sb_check();

        // reset mid-operation
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        push("mid_rst_err", 3, 0); push("mid_rst_epoch", 0, 0); push("mid_rst_in0", 4, 0);
        sb_check();
        rst = 1'b0;
        @(negedge clk);
        push("mid_rst_aligned", 1, 3'b100);
        sb_check();
        idle(3);
        push("no_stale_grant", 1, 3'b100);
        sb_check();

        // skew stall on the MAX_SKEW=4 instance
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); s_inc2 = 2'b01;
        end
        @(negedge clk); s_inc2 = 2'b00;
        push("skew_below", 8, 0);
        sb_check();
        s_inc2 = 2'b01;
        @(negedge clk);
        @(negedge clk); s_inc2 = 2'b00;
        @(negedge clk);
        push("skew_stall", 8, 2'b01); push("skew_drop_in0", 9, 4);
        sb_check();
        @(negedge clk); s_dec2 = 2'b01;
        @(negedge clk); s_dec2 = 2'b00;
        push("skew_release", 8, 0);
        sb_check();

        // disable port1, advance port0 to 5, re-enable port1
        do_reset();
        port_en = 2'b01;
        repeat (5) cyc(2'b01, 2'b00);
        idle(3);
        push("dis_epoch", 0, 5); push("dis_ctrl", 1, 3'b001);
        sb_check();
        @(negedge clk); port_en = 2'b11;
        idle(2);
        push("reen_in1", 5, 5); push("reen_out1", 7, 5); push("reen_epoch", 0, 5);
        sb_check();
        repeat (5) cyc(2'b00, 2'b01);
        idle(2);
        push("drain_aligned", 1, 3'b100); push("drain_err", 3, 0);
        sb_check();

        // wrap: 65536 arrivals on both ports, 65535 matched departures
        do_reset();
        begin
            int inc_n = 0;
            int dec_n [2] = '{0, 0};
            int budget = 70000;
            while ((inc_n < 65536 || dec_n[0] < 65535 || dec_n[1] < 65535) && budget > 0) begin
                @(negedge clk);
                budget--;
                s_inc = (inc_n < 65536) ? 2'b11 : 2'b00;
                if (inc_n < 65536) inc_n++;
                for (int p = 0; p < 2; p++) begin
                    s_dec[p] = ctrl_barrier[p] && (dec_n[p] < 65535);
                    if (s_dec[p]) dec_n[p]++;
                end
            end
            chk("wrap_budget", 32'(budget > 0), 1);
        end
        idle(4);
        push("wrap_epoch", 0, 0); push("wrap_ctrl", 1, 3'b011);
        push("wrap_err", 3, 0); push("wrap_in0", 4, 0);
        sb_check();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/epoch_barrier.md
EPOCH_BARRIER -- requirements
Module: epoch_barrier

Interface
REQ-001 Parameter PORT_COUNT, default 2, number of barrier ports (1..16).
REQ-002 Parameter COUNT_WIDTH, default 16, width of each per-port arrival/departure counter.
REQ-003 Parameter MAX_SKEW, default 1024, max allowed arrivals-minus-departures per port; must be < 2^(COUNT_WIDTH-1).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 s_inc  input  PORT_COUNT  per-port arrival pulse, one event per cycle.
REQ-007 s_dec  input  PORT_COUNT  per-port departure pulse, one event per cycle.
REQ-008 port_en  input  PORT_COUNT  per-port participation mask; disabled ports are excluded from the minimum.
REQ-009 ctrl_barrier  output  PORT_COUNT+1  bit i = port i may depart; bit PORT_COUNT = all enabled ports aligned.
REQ-010 skew_stall  output  PORT_COUNT  port i has hit MAX_SKEW; upstream must stop s_inc[i].
REQ-011 err_underflow  output  PORT_COUNT  sticky; s_dec[i] was seen without a grant.
REQ-012 epoch  output  COUNT_WIDTH  current global epoch, i.e. the minimum arrival count over enabled ports.

Function
REQ-013 Per port: arrival counter in_cnt[i] and departure counter out_cnt[i], COUNT_WIDTH bits, modulo 2^COUNT_WIDTH (wrap is legal).
REQ-014 s_inc[i] high: in_cnt[i] += 1 next cycle. s_dec[i] high: out_cnt[i] += 1 next cycle. Both high in the same cycle: both update, with no priority.
REQ-015 An inc on a port with skew_stall[i]=1 is dropped; the counter is unchanged.
REQ-016 Wrap-safe compare: each enabled port's offset is off[i] = (in_cnt[i] - epoch) mod 2^COUNT_WIDTH, treated as unsigned.
REQ-017 Next epoch = epoch + min(off[i]) over enabled ports. If no port is enabled, epoch holds.
REQ-018 Epoch never decreases. The update is registered, so epoch reflects arrivals with 1-cycle latency.
REQ-019 lag[i] = (epoch - out_cnt[i]) mod 2^COUNT_WIDTH.
REQ-020 ctrl_barrier[i] = registered (port_en[i] and lag[i] != 0 and lag[i] < 2^(COUNT_WIDTH-1)).
REQ-021 Grant latency: ctrl_barrier[i] rises at most 2 cycles after the arrival that completes the epoch.
REQ-022 A grant with lag[i]=1 followed by s_dec[i] drops ctrl_barrier[i] on the next cycle.
REQ-023 ctrl_barrier[PORT_COUNT] = registered (all enabled ports have off[i]==0 and lag[i]==0). It is 1 when no port is enabled.
REQ-024 skew_stall[i] = registered ((in_cnt[i] - out_cnt[i]) mod 2^COUNT_WIDTH >= MAX_SKEW).
REQ-025 s_dec[i] with ctrl_barrier[i]=0:
- out_cnt[i] is not updated;
- err_underflow[i] is set and holds until rst.
REQ-026 Disabling a port (port_en[i] 1->0) freezes its counters. The port is excluded from the min the next cycle.
REQ-027 Re-enabling a port loads in_cnt[i] and out_cnt[i] with the current epoch, so a stale port cannot pull the epoch backward.

Reset
REQ-028 On rst=1 at a rising edge, the following are cleared to 0:
- all in_cnt and out_cnt;
- epoch, ctrl_barrier, skew_stall and err_underflow.
REQ-029 rst asserted mid-operation discards all in-flight counts. The first grant after rst requires fresh arrivals.
REQ-030 The cycle after rst deassertion: ctrl_barrier[PORT_COUNT] = 1 if any port is enabled and all counts are 0.

Verification
REQ-031 P=2, both enabled: inc port0 x3, inc port1 x1 -> epoch=1, ctrl_barrier[1:0]=11; one dec on each -> ctrl_barrier[1:0]=00, ctrl_barrier[2]=0 (port0 in_cnt=3 > epoch 1).
REQ-032 Wrap: preload via 65535 incs on both ports with matching decs, then one more inc on each (W=16) -> epoch wraps to 0, ctrl_barrier[1:0]=11, no err_underflow.
REQ-033 Simultaneous inc+dec on port0 while granted with lag=1 -> in_cnt+1, out_cnt+1, no error flag.
REQ-034 dec on port1 with ctrl_barrier[1]=0 -> err_underflow[1]=1 and sticky, out_cnt[1] unchanged.
REQ-035 MAX_SKEW=4: 5 incs on port0 without decs -> skew_stall[0]=1 after the 4th, 5th inc dropped, in_cnt[0]=4.
REQ-036 port1 disabled while port0 advances to 5 -> epoch=5; re-enable port1 -> its counts load 5, ctrl_barrier[2]=1 once port0 drains.
